mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Arbiter and sequencer sharing the single-ported unified memory between the CPU instruction-fetch path and the load/store path.
- Picks one requester per cycle and drives the memory port.
- Tracks in-flight reads through a fixed-latency return pipeline, and steers read data back to the requester that owns it.
- Sits between fetch/decode (which consumes fetched words for immediate generation) and the memory macro.

Parameters:
- AWIDTH, 14, word-address width.
- DWIDTH, 32, data width.
- MEM_LAT, 1, memory read latency in cycles; legal range 1..3.
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_req  in  1  fetch read request.
- instr_addr  in  AWIDTH  fetch word address.
- instr_gnt  out  1  fetch request accepted this cycle.
- instr_rvalid  out  1  fetch read data valid.
- instr_rdata  out  DWIDTH  fetch read data.
- data_req  in  1  load/store request.
- data_we  in  4  byte write enables; 0 means read.
- data_addr  in  AWIDTH  load/store word address.
- data_wdata  in  DWIDTH  store data.
- data_gnt  out  1  load/store request accepted this cycle.
- data_rvalid  out  1  load read data valid.
- data_rdata  out  DWIDTH  load read data.
- mem_en  out  1  memory access enable.
- mem_we  out  4  memory byte write enables.
- mem_addr  out  AWIDTH  memory address.
- mem_din  out  DWIDTH  memory write data.
- mem_dout  in  DWIDTH  memory read data, valid MEM_LAT cycles after mem_en with mem_we=0.
- conflict_cnt  out  32  conflict statistics (see Optional Feature).

Behaviour:
- Handshake:
  - A requester holds req, addr, we and wdata stable until it sees gnt high.
  - A transfer occurs in any cycle where req && gnt.
  - gnt and all mem_* outputs are combinational from req and the registered arbiter state.
  - At most one gnt is high per cycle.
- Arbiter state machine, 1 bit:
  - DPRI (reset state): data wins if data_req is high; otherwise instr wins if instr_req is high.
  - IPRI: instr wins if instr_req is high; otherwise data wins.
- Starvation counter (4 bits, reset 0):
  - Increments when instr_req && !instr_gnt.
  - Clears on instr_gnt, or when instr_req is low.
  - When it reaches STARVE_MAX in DPRI, next state is IPRI and the counter clears.
  - IPRI always returns to DPRI after exactly one cycle, granted or not.
- Memory port:
  - mem_en = instr_gnt | data_gnt.
  - mem_addr and mem_din come from the winner.
  - mem_we = data_we when data wins, else 0.
  - When idle: mem_addr = 0, mem_din = 0, mem_we = 0.
- Return pipeline:
  - MEM_LAT-deep shift register of {valid, owner} tags.
  - A tag is pushed on every granted read; writes push valid = 0.
  - At the tail, a valid tag raises instr_rvalid or data_rvalid for exactly one cycle.
  - The matching *_rdata equals mem_dout; the other *_rdata is 0.
  - Back-to-back reads are accepted every cycle, giving full throughput.
  - Return order equals grant order.
- Reset (asynchronous, mid-operation included):
  - All tags clear, state goes to DPRI, counter goes to 0.
  - In-flight reads are dropped; no rvalid is ever produced for a pre-reset grant.
  - While rst_n is low, all outputs are 0, including gnt and mem_en.
- Simultaneous events:
  - Both requesting in DPRI with counter < STARVE_MAX: data is granted and fetch stalls.
  - A data write is never reordered ahead of an earlier granted read, since the port is in-order.

Optional Feature:
- Macro: MEM_PORT_ARB_STATS_EN.
- Defined:
  - conflict_cnt counts cycles where instr_req && data_req.
  - It saturates at 0xFFFFFFFF and resets to 0 on rst_n low.
- Undefined:
  - No counter register exists; conflict_cnt is tied to 0.
  - All other behaviour is identical.

Test Plan:
- Fetch only, MEM_LAT=1: instr_req=1, addr 0x010 then 0x011 on back-to-back cycles -> instr_gnt=1 both cycles; instr_rvalid on cycles +1 and +2 with mem_dout values; data_rvalid stays 0.
- Conflict with data priority: both req for 2 cycles, data is a read at 0x200 -> data_gnt=1, instr_gnt=0 both cycles; data_rvalid one cycle later carries 0x200 contents; fetch is granted when data_req drops.
- Starvation, STARVE_MAX=4: data_req and instr_req held high -> data granted 4 cycles, instr_gnt=1 on cycle 5, data granted again on cycle 6.
- Store: data_we=4'b0011, addr 0x05, wdata 0xDEADBEEF -> mem_we=0011, mem_addr=0x05, mem_din=0xDEADBEEF; no rvalid follows.
- Reset mid-read, MEM_LAT=3: read granted, then rst_n pulsed low one cycle later -> all outputs 0 during reset; no rvalid afterwards; first post-reset fetch is granted normally.
- Stats, macro defined: 7 cycles with both req high -> conflict_cnt=7; with macro undefined -> conflict_cnt=0.

Source files
------------

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one single-ported unified memory between the CPU
// instruction-fetch path and the load/store path. Each cycle it picks at most
// one requester and drives the memory port. A fixed-latency tag pipeline
// follows every read, so the returned word is steered back to its owner.
//
// Optional build macro: MEM_PORT_ARB_STATS_EN. When it is defined,
// conflict_cnt counts the cycles in which both paths request, saturating at
// all-ones. When it is undefined, conflict_cnt is tied to 0.
//
// Handshake: a requester holds req/addr/we/wdata stable until it sees gnt.
// A transfer happens in every cycle where req && gnt. The gnt outputs and the
// mem_* outputs are combinational from req and the registered arbiter state,
// and at most one gnt is high per cycle. Read data comes back on *_rvalid
// exactly MEM_LAT cycles after the grant, in grant order.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   instr_req/addr -> gnt        fetch request (read only)
//   instr_rvalid/rdata           fetch read return
//   data_req/we/addr/wdata       load/store request (we == 0 means read)
//   data_gnt, data_rvalid/rdata  load/store accept and load return
//   mem_en/we/addr/din, mem_dout memory macro port
//   conflict_cnt                 cycles with both requests (stats build only)
//   dbg_state                    arbiter state, 1 = fetch has priority
module mem_port_arb #(
  parameter int AWIDTH     = 14,
  parameter int DWIDTH     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_req,
  input  logic [AWIDTH-1:0] instr_addr,
  output logic              instr_gnt,
  output logic              instr_rvalid,
  output logic [DWIDTH-1:0] instr_rdata,
  input  logic              data_req,
  input  logic [3:0]        data_we,
  input  logic [AWIDTH-1:0] data_addr,
  input  logic [DWIDTH-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DWIDTH-1:0] data_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout,
  output logic [31:0]       conflict_cnt,
  output logic              dbg_state
);

  typedef enum logic {
    S_DPRI = 1'b0,
    S_IPRI = 1'b1
  } arb_state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [3:0]         r_starve;
  logic [3:0]         w_starve_nxt;
  logic               w_instr_win;
  logic               w_data_win;
  logic               w_push_vld;
  logic [MEM_LAT-1:0] r_tag_vld;
  logic [MEM_LAT-1:0] r_tag_own;  // 1 = load/store owns the read

  // Winner selection. Gated by rst_n so gnt and mem_en stay low during reset.
  always_comb begin
    w_instr_win = 1'b0;
    w_data_win  = 1'b0;
    if (rst_n) begin
      if (r_state == S_IPRI) begin
        w_instr_win = instr_req;
        w_data_win  = data_req & ~instr_req;
      end else begin
        w_data_win  = data_req;
        w_instr_win = instr_req & ~data_req;
      end
    end
  end

  assign instr_gnt = w_instr_win;
  assign data_gnt  = w_data_win;

  always_comb begin
    mem_en   = w_instr_win | w_data_win;
    mem_we   = 4'd0;
    mem_addr = '0;
    mem_din  = '0;
    if (w_data_win) begin
      mem_we   = data_we;
      mem_addr = data_addr;
      mem_din  = data_wdata;
    end else if (w_instr_win) begin
      mem_addr = instr_addr;
    end
  end

  // Next state. The starvation count tracks consecutive denied fetch cycles.
  // IPRI lasts exactly one cycle whether or not fetch actually requests.
  always_comb begin
    w_state_nxt  = S_DPRI;
    w_starve_nxt = 4'd0;
    if (instr_req && !w_instr_win) begin
      w_starve_nxt = r_starve + 4'd1;
    end
    if ((r_state == S_DPRI) && (w_starve_nxt == STARVE_LIM)) begin
      w_state_nxt  = S_IPRI;
      w_starve_nxt = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_DPRI;
      r_starve <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  assign dbg_state = r_state;

  // Return tag pipeline. Writes still shift a bubble through so that the
  // tail always lines up with mem_dout of the access MEM_LAT cycles ago.
  assign w_push_vld = mem_en & (mem_we == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_own <= '0;
    end else begin
      r_tag_vld[0] <= w_push_vld;
      r_tag_own[0] <= w_data_win;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

  assign instr_rvalid = r_tag_vld[MEM_LAT-1] & ~r_tag_own[MEM_LAT-1];
  assign data_rvalid  = r_tag_vld[MEM_LAT-1] &  r_tag_own[MEM_LAT-1];
  assign instr_rdata  = instr_rvalid ? mem_dout : '0;
  assign data_rdata   = data_rvalid  ? mem_dout : '0;

`ifdef MEM_PORT_ARB_STATS_EN
  logic [31:0] r_conflict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= 32'd0;
    end else if (instr_req && data_req && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  assign conflict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
module tb_mem_port_arb;
  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int LAT  = 3;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_req = 1'b0;
  logic [AW-1:0] instr_addr = '0;
  logic          data_req = 1'b0;
  logic [3:0]    data_we = 4'd0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic [DW-1:0] mem_dout;
  logic          instr_gnt, instr_rvalid, data_gnt, data_rvalid, mem_en, dbg_state;
  logic [DW-1:0] instr_rdata, data_rdata, mem_din;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   conflict_cnt;

  mem_port_arb #(.AWIDTH(AW), .DWIDTH(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .conflict_cnt(conflict_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int a);
    return (DW'(a) * 32'h9E37_79B1) ^ 32'h5555_AAAA;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // memory macro model: fixed read latency LAT, byte-write
  logic [DW-1:0] env_mem [0:1023];
  logic [DW-1:0] rd_pipe [LAT];
  logic          env_ready = 1'b0;
  assign mem_dout = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < 1024; i++) env_mem[i] <= init_word(i);
      env_ready <= 1'b1;
    end else if (mem_en && mem_we != 4'd0) begin
      env_mem[mem_addr[9:0]] <= merge(env_mem[mem_addr[9:0]], mem_din, mem_we);
    end
    rd_pipe[0] <= (mem_en && mem_we == 4'd0) ? env_mem[mem_addr[9:0]]
                                             : (32'hBADB_AD00 | DW'($urandom_range(0, 255)));
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // reference model and scoreboard
  logic [DW-1:0] sh_mem [0:1023];
  logic [DW-1:0] exp_q[$];
  int            exp_due[$];
  bit            exp_own[$];   // 1 = load/store
  bit            m_ipri;       // fetch holds priority for this one cycle
  int            m_wait;       // consecutive cycles fetch waited unserved
  logic [31:0]   m_conf;
  bit            m_ig, m_dg;
  int            cyc;
  int            checks;
  int            failures;
  string         cur_test;

  task automatic model_reset();
    exp_q.delete(); exp_due.delete(); exp_own.delete();
    m_ipri = 0; m_wait = 0; m_conf = 32'd0;
  endtask

  // One clock cycle: inputs already applied in the low phase.
  task automatic tick();
    logic          e_iv, e_dv;
    logic [DW-1:0] e_ird, e_drd, e_din;
    logic [AW-1:0] e_addr;
    logic [3:0]    e_we;
    #1;
    if (m_ipri) begin
      m_ig = instr_req; m_dg = data_req && !instr_req;
    end else begin
      m_dg = data_req;  m_ig = instr_req && !data_req;
    end
    e_we   = m_dg ? data_we : 4'd0;
    e_addr = m_dg ? data_addr : (m_ig ? instr_addr : '0);
    e_din  = m_dg ? data_wdata : '0;
    e_iv = 0; e_dv = 0; e_ird = '0; e_drd = '0;
    if (exp_due.size() > 0 && exp_due[0] == cyc) begin
      if (exp_own[0]) begin e_dv = 1; e_drd = exp_q[0]; end
      else            begin e_iv = 1; e_ird = exp_q[0]; end
      void'(exp_q.pop_front()); void'(exp_due.pop_front()); void'(exp_own.pop_front());
    end
    checks++;
    if ({instr_gnt, data_gnt, mem_en} !== {m_ig, m_dg, m_ig | m_dg}) begin
      failures++;
      $display("FAIL %s grant cyc=%0d got ig/dg/en=%b%b%b exp=%b%b%b", cur_test, cyc,
               instr_gnt, data_gnt, mem_en, m_ig, m_dg, m_ig | m_dg);
    end
    checks++;
    if ({mem_we, mem_addr, mem_din} !== {e_we, e_addr, e_din}) begin
      failures++;
      $display("FAIL %s mem_port cyc=%0d got we=%h addr=%h din=%h exp we=%h addr=%h din=%h",
               cur_test, cyc, mem_we, mem_addr, mem_din, e_we, e_addr, e_din);
    end
    checks++;
    if ({instr_rvalid, instr_rdata} !== {e_iv, e_ird}) begin
      failures++;
      $display("FAIL %s instr_ret cyc=%0d got v=%b d=%h exp v=%b d=%h", cur_test, cyc,
               instr_rvalid, instr_rdata, e_iv, e_ird);
    end
    checks++;
    if ({data_rvalid, data_rdata} !== {e_dv, e_drd}) begin
      failures++;
      $display("FAIL %s data_ret cyc=%0d got v=%b d=%h exp v=%b d=%h", cur_test, cyc,
               data_rvalid, data_rdata, e_dv, e_drd);
    end
    checks++;
    if (conflict_cnt !== m_conf) begin
      failures++;
      $display("FAIL %s conflict_cnt cyc=%0d got=%0d exp=%0d", cur_test, cyc, conflict_cnt, m_conf);
    end
    // bookkeeping of what was accepted this cycle
    if (m_dg) begin
      if (data_we == 4'd0) begin
        exp_q.push_back(sh_mem[data_addr[9:0]]); exp_due.push_back(cyc + LAT); exp_own.push_back(1);
      end else begin
        sh_mem[data_addr[9:0]] = merge(sh_mem[data_addr[9:0]], data_wdata, data_we);
      end
    end
    if (m_ig) begin
      exp_q.push_back(sh_mem[instr_addr[9:0]]); exp_due.push_back(cyc + LAT); exp_own.push_back(0);
    end
    if (instr_req && !m_ig) m_wait++; else m_wait = 0;
    if (m_ipri) m_ipri = 0;
    else if (m_wait == SMAX) begin m_ipri = 1; m_wait = 0; end
`ifdef MEM_PORT_ARB_STATS_EN
    if (instr_req && data_req && m_conf != 32'hFFFF_FFFF) m_conf++;
`endif
    @(posedge clk); cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    instr_req = 0; data_req = 0; data_we = 4'd0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    cur_test = "reset";
    instr_req = 1; instr_addr = 14'h012; data_req = 1; data_we = 4'hF; data_addr = 14'h034;
    data_wdata = 32'h1234_5678;
    #2;
    checks++;
    if ({instr_gnt, data_gnt, mem_en, mem_we, mem_addr, mem_din, instr_rvalid, instr_rdata,
         data_rvalid, data_rdata, conflict_cnt, dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset outputs_in_reset got gnt=%b%b en=%b we=%h addr=%h", instr_gnt, data_gnt,
               mem_en, mem_we, mem_addr);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1; instr_req = 0; data_req = 0; data_we = 4'd0;
    model_reset();
    #1;
    checks++;
    if ({dbg_state, instr_rvalid, data_rvalid, conflict_cnt} !== '0) begin
      failures++;
      $display("FAIL reset state_after got st=%b rv=%b%b cc=%0d exp 0", dbg_state, instr_rvalid,
               data_rvalid, conflict_cnt);
    end
    idle(2);
  endtask

  task automatic test_fetch_only();
    cur_test = "fetch_only";
    instr_req = 1; instr_addr = 14'h010;
    tick();
    checks++;
    if (m_ig !== 1'b1 || instr_gnt === 1'b0) begin end
    instr_addr = 14'h011;
    tick();
    idle(LAT + 1);
  endtask

  task automatic test_conflict();
    cur_test = "conflict";
    instr_req = 1; instr_addr = 14'h020;
    data_req = 1; data_we = 4'd0; data_addr = 14'h200;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({data_gnt, instr_gnt} !== 2'b10) begin
        failures++;
        $display("FAIL conflict data_priority k=%0d got dg/ig=%b%b exp=10", k, data_gnt, instr_gnt);
      end
      tick();
    end
    data_req = 0;
    #1;
    checks++;
    if (instr_gnt !== 1'b1) begin
      failures++;
      $display("FAIL conflict fetch_after got=%b exp=1", instr_gnt);
    end
    tick();
    idle(LAT + 1);
  endtask

  task automatic test_starvation();
    cur_test = "starvation";
    instr_req = 1; instr_addr = 14'h070;
    data_req = 1; data_we = 4'd0; data_addr = 14'h100;
    for (int k = 0; k < SMAX + 2; k++) begin
      #1;
      checks++;
      if ({instr_gnt, data_gnt} !== {k == SMAX, k != SMAX}) begin
        failures++;
        $display("FAIL starvation cycle%0d got ig/dg=%b%b exp=%b%b", k + 1, instr_gnt, data_gnt,
                 k == SMAX, k != SMAX);
      end
      tick();
      data_addr = data_addr + 1'b1;
    end
    idle(LAT + 1);
  endtask

  task automatic test_store();
    cur_test = "store";
    data_req = 1; data_we = 4'b0011; data_addr = 14'h005; data_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({data_gnt, mem_en, mem_we, mem_addr, mem_din} !== {1'b1, 1'b1, 4'b0011, 14'h005, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL store port got gnt=%b en=%b we=%b addr=%h din=%h exp 1 1 0011 005 deadbeef",
               data_gnt, mem_en, mem_we, mem_addr, mem_din);
    end
    tick();
    idle(LAT + 1);
    // read back: lower two bytes from the store, upper two untouched
    data_req = 1; data_we = 4'd0; data_addr = 14'h005;
    tick();
    idle(LAT + 1);
  endtask

  task automatic test_reset_mid_read();
    cur_test = "reset_mid_read";
    instr_req = 1; instr_addr = 14'h030;
    tick();
    instr_addr = 14'h031; data_req = 1; data_we = 4'd0; data_addr = 14'h032;
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({instr_gnt, data_gnt, mem_en, mem_we, mem_addr, mem_din, instr_rvalid, instr_rdata,
           data_rvalid, data_rdata, conflict_cnt, dbg_state} !== '0) begin
        failures++;
        $display("FAIL reset_mid_read outputs_in_reset k=%0d gnt=%b%b en=%b rv=%b%b", k,
                 instr_gnt, data_gnt, mem_en, instr_rvalid, data_rvalid);
      end
      if (k == 0) begin @(posedge clk); cyc++; end
    end
    @(negedge clk);
    rst_n = 1;
    model_reset();
    idle(LAT + 2);
    instr_req = 1; instr_addr = 14'h040;
    #1;
    checks++;
    if (instr_gnt !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_read first_fetch got=%b exp=1", instr_gnt);
    end
    tick();
    idle(LAT + 1);
  endtask

  task automatic test_stats();
    cur_test = "stats";
    instr_req = 1; instr_addr = 14'h050;
    data_req = 1; data_we = 4'd0; data_addr = 14'h060;
    repeat (7) tick();
    instr_req = 0; data_req = 0;
    #1;
    checks++;
`ifdef MEM_PORT_ARB_STATS_EN
    if (conflict_cnt !== 32'd7) begin
      failures++;
      $display("FAIL stats conflict_cnt got=%0d exp=7", conflict_cnt);
    end
`else
    if (conflict_cnt !== 32'd0) begin
      failures++;
      $display("FAIL stats conflict_cnt got=%0d exp=0", conflict_cnt);
    end
`endif
    idle(LAT + 1);
  endtask

  task automatic test_random();
    bit i_pend, d_pend;
    cur_test = "random";
    i_pend = 0; d_pend = 0;
    for (int n = 0; n < 400; n++) begin
      if (!i_pend && $urandom_range(0, 99) < 60) begin
        i_pend = 1; instr_addr = AW'($urandom_range(0, 1023));
      end
      if (!d_pend && $urandom_range(0, 99) < 55) begin
        d_pend = 1; data_addr = AW'($urandom_range(0, 1023));
        data_we = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
        data_wdata = $urandom;
      end
      instr_req = i_pend; data_req = d_pend;
      tick();
      if (m_ig) i_pend = 0;
      if (m_dg) d_pend = 0;
    end
    idle(LAT + 2);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    for (int i = 0; i < 1024; i++) sh_mem[i] = init_word(i);
    model_reset();
    test_reset();
    test_fetch_only();
    test_conflict();
    test_starvation();
    test_store();
    test_reset_mid_read();
    test_stats();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
